// File: rtl/spi_flash_xip.sv
// Read-only execute-in-place SPI flash controller: single-SPI READ (0x03) of
// 32-bit words, with continuation of an open transaction on sequential fetches.
`timescale 1ns/1ps
module spi_flash_xip #(
  parameter int CSB_HIGH_CYCLES  = 4,
  parameter int WAKE_WAIT_CYCLES = 40,
  parameter bit ENABLE_BURST     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_oe,
  output logic        flash_io0_do,
  input  logic        flash_io1_di,
  output logic        flash_io23_do
);

  typedef enum logic [3:0] {
    S_INIT_GAP,
    S_WAKE,
    S_WAKE_WAIT,
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE,
    S_OPEN,
    S_GAP
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CSB_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAKE_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(63);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic [21:0]      word_q;
  logic [21:0]      next_word;
  logic [31:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic             tx_load;
  logic [31:0]      tx_load_val;
  logic             addr_latch;
  logic             word_inc;
  logic             rdata_load;
  logic             unused_bits;

  function automatic logic [31:0] read_cmd(input logic [21:0] w);
    return {8'h03, w, 2'b00};
  endfunction

  // First byte shifted in lands in the least significant byte.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign next_word   = word_q + 22'd1;
  assign unused_bits = ^{addr[1:0], rx_sr[31]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT_GAP;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    pend_nxt    = pend;
    tx_load     = 1'b0;
    tx_load_val = read_cmd(addr[23:2]);
    addr_latch  = 1'b0;
    word_inc    = 1'b0;
    rdata_load  = 1'b0;
    case (state)
      S_INIT_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt   = S_WAKE;
          cnt_nxt     = '0;
          tx_load     = 1'b1;
          tx_load_val = {8'hAB, 24'h000000};
        end
      end
      S_WAKE: begin
        if (cnt == WAKE_LAST) begin
          state_nxt = S_WAKE_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAKE_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        cnt_nxt = '0;
        if (valid) begin
          addr_latch = 1'b1;
          tx_load    = 1'b1;
          state_nxt  = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt == WORD_LAST) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (cnt == WORD_LAST) begin
          state_nxt  = S_DONE;
          cnt_nxt    = '0;
          rdata_load = 1'b1;
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = ENABLE_BURST ? S_OPEN : S_GAP;
      end
      S_OPEN: begin
        // Flash keeps streaming while csb stays low, so a sequential word needs no command.
        cnt_nxt = '0;
        if (valid) begin
          if (addr[23:2] == next_word) begin
            word_inc  = 1'b1;
            state_nxt = S_DATA;
          end else begin
            addr_latch = 1'b1;
            pend_nxt   = 1'b1;
            state_nxt  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt  = '0;
          pend_nxt = 1'b0;
          if (pend) begin
            state_nxt   = S_CMD;
            tx_load     = 1'b1;
            tx_load_val = read_cmd(word_q);
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (valid && !pend) begin
          addr_latch = 1'b1;
          pend_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_INIT_GAP;
        cnt_nxt   = '0;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  // Odd counter values are the high phase; shifting happens on the edge that ends it.
  always_ff @(posedge clk) begin
    if (addr_latch) begin
      word_q <= addr[23:2];
    end else if (word_inc) begin
      word_q <= next_word;
    end
    if (tx_load) begin
      tx_sr <= tx_load_val;
    end else if (cnt[0]) begin
      tx_sr <= {tx_sr[30:0], 1'b0};
    end
    if (state == S_DATA && cnt[0]) begin
      rx_sr <= {rx_sr[30:0], flash_io1_di};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rdata_load) begin
      rdata <= swap_bytes({rx_sr[30:0], flash_io1_di});
    end
  end

  assign ready         = (state == S_DONE);
  assign flash_csb     = !(state inside {S_WAKE, S_CMD, S_DATA, S_DONE, S_OPEN});
  assign flash_clk     = (state inside {S_WAKE, S_CMD, S_DATA}) && cnt[0];
  assign flash_io0_do  = (state inside {S_WAKE, S_CMD}) && tx_sr[31];
  assign flash_io0_oe  = !flash_csb;
  assign flash_io23_do = 1'b1;

endmodule

// File: tb/tb_spi_flash_xip.sv
// Bench for spi_flash_xip: behavioural SPI flash that decodes the pins, plus
// latency/data expectations derived from addresses and the protocol rules.
`timescale 1ns/1ps
module tb_spi_flash_xip;

  localparam int CSB_HIGH  = 4;
  localparam int WAKE_WAIT = 40;
  localparam int LAT_IDLE  = 129;
  localparam int LAT_SEQ   = 65;
  localparam int LAT_NSEQ  = CSB_HIGH + 129;
  localparam int LAT_BOOT  = CSB_HIGH + 16 + WAKE_WAIT + LAT_IDLE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [23:0] addr = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0_oe;
  logic        flash_io0_do;
  logic        flash_io1_di = 1'b0;
  logic        flash_io23_do;

  spi_flash_xip #(
    .CSB_HIGH_CYCLES (CSB_HIGH),
    .WAKE_WAIT_CYCLES(WAKE_WAIT),
    .ENABLE_BURST    (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .ready        (ready),
    .addr         (addr),
    .rdata        (rdata),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_oe (flash_io0_oe),
    .flash_io0_do (flash_io0_do),
    .flash_io1_di (flash_io1_di),
    .flash_io23_do(flash_io23_do)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash contents: a few preloaded bytes, everything else a fixed hash of the address.
  logic [7:0] mem [int];

  function automatic logic [7:0] fbyte(input int a);
    int m;
    logic [31:0] h;
    m = a & 32'h00FF_FFFF;
    if (mem.exists(m)) return mem[m];
    h = m * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    int b;
    b = int'(a);
    return {fbyte(b + 3), fbyte(b + 2), fbyte(b + 1), fbyte(b)};
  endfunction

  // Pin-level flash model, evaluated mid-cycle.
  logic        m_prev_clk = 1'b0;
  logic        m_prev_csb = 1'b1;
  int          m_bits = 0;
  logic [31:0] m_sr = '0;
  int          m_low_len = 0;
  int          m_high_len = 0;
  logic        m_seg_wake = 1'b0;
  logic        m_is_read = 1'b0;
  int          m_rd_addr = 0;
  int          csb_rise_cnt = 0;
  int          wake_seen = 0;
  int          cmd_cnt = 0;
  logic [31:0] last_cmd = '0;
  int          wake_low_len = 0;
  int          last_high_len = 0;
  int          oe_bad = 0;
  int          rdy_dbl = 0;
  logic        prev_rdy = 1'b0;

  always @(negedge clk) begin : flash_model
    int k;
    logic [7:0] b;
    if (flash_io0_oe !== !flash_csb) oe_bad++;
    if (ready && prev_rdy) rdy_dbl++;
    prev_rdy = ready;
    if (flash_csb) begin
      if (!m_prev_csb) begin
        csb_rise_cnt++;
        if (m_seg_wake) wake_low_len = m_low_len;
      end
      m_high_len++;
      m_bits = 0;
      m_low_len = 0;
      m_seg_wake = 1'b0;
      m_is_read = 1'b0;
    end else begin
      if (m_prev_csb) begin
        last_high_len = m_high_len;
        m_high_len = 0;
      end
      m_low_len++;
      if (flash_clk && !m_prev_clk) begin
        if (m_bits < 32) m_sr = {m_sr[30:0], flash_io0_do};
        m_bits++;
        if (m_bits == 8 && m_sr[7:0] == 8'hAB) begin
          wake_seen++;
          m_seg_wake = 1'b1;
        end
        if (m_bits == 32 && m_sr[31:24] == 8'h03) begin
          cmd_cnt++;
          last_cmd = m_sr;
          m_rd_addr = int'(m_sr[23:0]);
          m_is_read = 1'b1;
        end
      end
      if (!flash_clk && m_prev_clk && m_is_read && m_bits >= 32) begin
        k = m_bits - 32;
        b = fbyte(m_rd_addr + k / 8);
        flash_io1_di = b[7 - (k % 8)];
      end
    end
    m_prev_csb = flash_csb;
    m_prev_clk = flash_clk;
  end

  // Called at a negedge; issues one word read and checks latency and data.
  task automatic do_read(input logic [23:0] a, input int gap, input int exp_lat,
                         input bit drop, input string tag);
    int n;
    repeat (gap) @(negedge clk);
    addr  = a | 24'($urandom_range(0, 3));
    valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 2) valid = 1'b0;
    end while (!ready && n < 400);
    valid = 1'b0;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_data"}, rdata, fword(a));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [23:0] prev;
    logic [23:0] a;
    int rise0, cmd0, w0, lat, n;

    mem[32'h020000] = 8'h11;
    mem[32'h020001] = 8'h22;
    mem[32'h020002] = 8'h33;
    mem[32'h020003] = 8'h44;

    repeat (3) @(negedge clk);
    chk("rst_csb", flash_csb, 1);
    chk("rst_clk", flash_clk, 0);
    chk("rst_oe", flash_io0_oe, 0);
    chk("rst_do", flash_io0_do, 0);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);

    reset = 1'b0;
    do_read(24'h020000, 0, LAT_BOOT, 1'b0, "boot");
    chk("boot_word", rdata, 32'h44332211);
    chk("wake_seen", wake_seen, 1);
    chk("wake_low_len", wake_low_len, 16);
    chk("boot_cmd", last_cmd, 32'h03020000);

    rise0 = csb_rise_cnt;
    cmd0  = cmd_cnt;
    do_read(24'h020004, 1, LAT_SEQ, 1'b0, "seq");
    chk("seq_norise", csb_rise_cnt, rise0);
    chk("seq_nocmd", cmd_cnt, cmd0);

    do_read(24'h030000, 1, LAT_NSEQ, 1'b0, "nseq");
    chk("nseq_gap", last_high_len >= CSB_HIGH, 1);
    chk("nseq_cmd", last_cmd, 32'h03030000);

    do_read(24'hFFFFFC, 2, LAT_NSEQ, 1'b0, "top");
    rise0 = csb_rise_cnt;
    do_read(24'h000000, 1, LAT_SEQ, 1'b0, "wrap");
    chk("wrap_norise", csb_rise_cnt, rise0);

    do_read(24'h000004, 1, LAT_SEQ, 1'b1, "drop");
    prev = 24'h000004;

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) a = prev + 24'd4;
      else a = 24'($urandom) & 24'hFFFFFC;
      lat = (a == prev + 24'd4) ? LAT_SEQ : LAT_NSEQ;
      do_read(a, $urandom_range(1, 3), lat, 1'b0, $sformatf("rnd%0d", i));
      prev = a;
    end

    @(negedge clk);
    addr  = 24'h123450;
    valid = 1'b1;
    n = 0;
    while (!(m_is_read && m_bits >= 43) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", n < 400, 1);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("abort_csb", flash_csb, 1);
    chk("abort_clk", flash_clk, 0);
    chk("abort_ready", ready, 0);
    chk("abort_rdata", rdata, 0);
    w0 = wake_seen;
    @(negedge clk);
    reset = 1'b0;
    do_read(24'h123450, 0, LAT_BOOT, 1'b0, "reboot");
    chk("rewake", wake_seen, w0 + 1);

    chk("oe_track", oe_bad, 0);
    chk("ready_single", rdy_dbl, 0);
    chk("io23", flash_io23_do, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
